// File: rtl/e203_nice_pkg.sv
// Shared types and defaults for the NICE long-pipe dispatch/writeback bridge.
package e203_nice_pkg;

  localparam int DEF_ITAG_W      = 2;
  localparam int DEF_DP          = 4;
  localparam int DEF_TO_W        = 16;
  localparam int DEF_TIMEOUT_CYC = 4096;

  typedef logic [DEF_ITAG_W-1:0] itag_t;

  // Width needed to hold an occupancy of 0..dp inclusive.
  function automatic int cnt_w(input int dp);
    return $clog2(dp + 1);
  endfunction

endpackage

// File: rtl/e203_nice_itag_queue.sv
// In-order ITAG FIFO for outstanding long-pipe instructions; any depth >= 1.
module e203_nice_itag_queue
  import e203_nice_pkg::*;
#(
  parameter  int DP = DEF_DP,
  parameter  int W  = DEF_ITAG_W,
  localparam int CW = cnt_w(DP)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wen,
  input  logic [W-1:0]  wdat,
  input  logic          ren,
  output logic [W-1:0]  rdat,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;

  logic [W-1:0]  r_mem [DP];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [CW-1:0] r_cnt;

  // Depth need not be a power of two, so wrap explicitly at the last slot.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DP - 1)) ? '0 : p + 1'b1;
  endfunction

  // NOTE: storage is deliberately not reset; validity is tracked by r_cnt,
  // and rdat is forced to zero while empty so stale entries never leak out.
  always_ff @(posedge clk) begin
    if (wen) r_mem[r_wptr] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (wen) r_wptr <= ptr_inc(r_wptr);
      if (ren) r_rptr <= ptr_inc(r_rptr);
      case ({wen, ren})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  assign full  = (r_cnt == CW'(DP));
  assign empty = (r_cnt == '0);
  assign count = r_cnt;
  assign rdat  = empty ? '0 : r_mem[r_rptr];

endmodule

// File: rtl/e203_exu_nice_lp.sv
// NICE dispatch/writeback bridge: issues long-pipe insns to the coprocessor,
// tracks their ITAGs in order, and watches for responses that never arrive.
module e203_exu_nice_lp
  import e203_nice_pkg::*;
#(
  parameter  int XLEN        = 32,
  parameter  int ITAG_W      = DEF_ITAG_W,
  parameter  int DP          = DEF_DP,
  parameter  int TO_W        = DEF_TO_W,
  parameter  int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  localparam int CW          = cnt_w(DP)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              nice_i_xs_off,
  input  logic              nice_i_valid,
  output logic              nice_i_ready,
  input  logic [XLEN-1:0]   nice_i_instr,
  input  logic [XLEN-1:0]   nice_i_rs1,
  input  logic [XLEN-1:0]   nice_i_rs2,
  input  logic [ITAG_W-1:0] nice_i_itag,
  output logic              nice_o_longpipe,
  output logic              nice_o_valid,
  input  logic              nice_o_ready,
  output logic              nice_req_valid,
  input  logic              nice_req_ready,
  output logic [XLEN-1:0]   nice_req_instr,
  output logic [XLEN-1:0]   nice_req_rs1,
  output logic [XLEN-1:0]   nice_req_rs2,
  input  logic              nice_rsp_multicyc_valid,
  input  logic              nice_rsp_multicyc_err,
  output logic              nice_rsp_multicyc_ready,
  output logic              nice_o_itag_valid,
  input  logic              nice_o_itag_ready,
  output logic [ITAG_W-1:0] nice_o_itag,
  output logic              nice_o_itag_err,
  output logic [CW-1:0]     nice_o_outstanding,
  output logic              nice_o_idle,
  output logic              nice_o_timeout,
  input  logic              nice_i_timeout_clr
);

  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);

  logic w_q_full;
  logic w_q_empty;
  logic w_q_ok;
  logic w_req_rdy_pos;
  logic w_wen;
  logic w_ren;
  logic w_wd_hit;

  logic [TO_W-1:0] r_wd_cnt;
  logic            r_timeout;

  // xs_off insns bypass the coprocessor, so neither queue space nor
  // request readiness may stall them.
  assign w_q_ok        = nice_i_xs_off | ~w_q_full;
  assign w_req_rdy_pos = nice_i_xs_off | nice_req_ready;

  assign nice_req_valid = ~nice_i_xs_off & nice_i_valid & nice_o_ready & ~w_q_full;
  assign nice_i_ready   = w_req_rdy_pos & nice_o_ready & w_q_ok;
  assign nice_o_valid   = nice_i_valid & w_req_rdy_pos & w_q_ok;
  assign nice_o_longpipe = ~nice_i_xs_off;

  assign nice_req_instr = nice_i_instr;
  assign nice_req_rs1   = nice_i_rs1;
  assign nice_req_rs2   = nice_i_rs2;

  assign w_wen = nice_req_valid & nice_req_ready;
  assign w_ren = nice_rsp_multicyc_valid & nice_rsp_multicyc_ready;

  assign nice_rsp_multicyc_ready = nice_o_itag_ready & ~w_q_empty;
  assign nice_o_itag_valid       = ~w_q_empty & nice_rsp_multicyc_valid;
  assign nice_o_itag_err         = nice_rsp_multicyc_err & nice_o_itag_valid;
  assign nice_o_idle             = w_q_empty;

  e203_nice_itag_queue #(
    .DP (DP),
    .W  (ITAG_W)
  ) u_itag_queue (
    .clk   (clk),
    .rst_n (rst_n),
    .wen   (w_wen),
    .wdat  (nice_i_itag),
    .ren   (w_ren),
    .rdat  (nice_o_itag),
    .full  (w_q_full),
    .empty (w_q_empty),
    .count (nice_o_outstanding)
  );

  // Watchdog measures how long the head entry has waited for its response.
  assign w_wd_hit = (TIMEOUT_CYC != 0) && (r_wd_cnt == TO_LIM);

  // NOTE: all sequential state uses non-blocking assignments so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wd_cnt <= '0;
    end else if (w_q_empty || w_ren) begin
      r_wd_cnt <= '0;
    end else if (r_wd_cnt != TO_LIM) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_timeout <= 1'b0;
    end else if (w_wd_hit) begin
      r_timeout <= 1'b1;
    end else if (nice_i_timeout_clr) begin
      r_timeout <= 1'b0;
    end
  end

  assign nice_o_timeout = r_timeout;

endmodule

// File: doc/e203_exu_nice_lp.md
Name: e203_exu_nice_lp

Overview:
- Next-generation NICE dispatch/writeback bridge between EXU dispatch/commit and the NICE coprocessor request/response channels.
- Generalises the long-pipe ITAG tracking with a configurable-depth ITAG queue whose full state gates dispatch.
- Adds an outstanding-count output, an idle indication, a per-response error flag carried with the ITAG, and a sticky watchdog for responses that never arrive.

Parameters:
XLEN, 32, data/instruction width
ITAG_W, 2, instruction tag width
DP, 4, ITAG queue depth (>=1, any integer, not required to be a power of two)
TO_W, 16, watchdog counter width
TIMEOUT_CYC, 4096, watchdog threshold in cycles; 0 disables the watchdog

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
nice_i_xs_off  in  1  NICE disabled; insn is not issued to the coprocessor
nice_i_valid  in  1  dispatch valid
nice_i_ready  out  1  dispatch ready
nice_i_instr  in  XLEN  instruction
nice_i_rs1  in  XLEN  operand 1
nice_i_rs2  in  XLEN  operand 2
nice_i_itag  in  ITAG_W  instruction tag
nice_o_longpipe  out  1  insn is long-pipe (= ~nice_i_xs_off)
nice_o_valid  out  1  commit valid
nice_o_ready  in  1  commit ready
nice_req_valid  out  1  coprocessor request valid
nice_req_ready  in  1  coprocessor request ready
nice_req_instr  out  XLEN  passthrough of nice_i_instr
nice_req_rs1  out  XLEN  passthrough of nice_i_rs1
nice_req_rs2  out  XLEN  passthrough of nice_i_rs2
nice_rsp_multicyc_valid  in  1  response valid
nice_rsp_multicyc_err  in  1  response error
nice_rsp_multicyc_ready  out  1  response ready
nice_o_itag_valid  out  1  writeback valid
nice_o_itag_ready  in  1  writeback ready
nice_o_itag  out  ITAG_W  head-of-queue tag
nice_o_itag_err  out  1  error flag qualified by nice_o_itag_valid
nice_o_outstanding  out  $clog2(DP+1)  queue occupancy
nice_o_idle  out  1  occupancy == 0
nice_o_timeout  out  1  sticky watchdog flag
nice_i_timeout_clr  in  1  clears nice_o_timeout

Behaviour:
- Reset: queue empty; pointers 0; count 0; watchdog counter 0; nice_o_timeout 0. After reset: nice_o_itag_valid=0, nice_rsp_multicyc_ready=0, nice_o_idle=1, nice_o_outstanding=0, nice_o_itag=0.
- q_full = (count == DP). q_ok = nice_i_xs_off | ~q_full.
- req_rdy_pos = nice_i_xs_off ? 1 : nice_req_ready.
- nice_req_valid = ~nice_i_xs_off & nice_i_valid & nice_o_ready & ~q_full.
- nice_i_ready = req_rdy_pos & nice_o_ready & q_ok.
- nice_o_valid = nice_i_valid & req_rdy_pos & q_ok.
- Full queue blocks new long-pipe issue. xs_off insns always pass and never enqueue.
- Enqueue (wen) = nice_req_valid & nice_req_ready. Stores nice_i_itag at the write pointer.
- Dequeue (ren) = nice_rsp_multicyc_valid & nice_rsp_multicyc_ready.
- nice_rsp_multicyc_ready = nice_o_itag_ready & ~empty.
- nice_o_itag_valid = ~empty & nice_rsp_multicyc_valid.
- nice_o_itag = entry at the read pointer, from registered storage. It has no combinational path from the response or request inputs.
- nice_o_itag_err = nice_rsp_multicyc_err & nice_o_itag_valid.
- Latency: an enqueued tag is visible at the head the cycle after wen. There is no same-cycle bypass, so an empty queue never returns a response.
- Pointer wrap: at DP-1 the pointer returns to 0.
- Count update: +1 on wen only, -1 on ren only, unchanged when both occur. Simultaneous wen and ren are legal at any non-empty occupancy. When full, wen is already 0.
- Watchdog:
  - The counter increments while the queue is non-empty and ren=0.
  - It clears on ren or when the queue is empty.
  - It saturates at TIMEOUT_CYC.
  - nice_o_timeout sets the cycle after the counter first equals TIMEOUT_CYC and holds until nice_i_timeout_clr. Set wins over a clear in the same cycle.
  - With TIMEOUT_CYC=0 the flag stays 0.
- nice_i_xs_off toggling while entries are outstanding does not flush. Responses still drain normally.
- Reset asserted mid-operation discards all entries on the next clk edge.

Decomposition:
- Package e203_nice_pkg holds:
  - the itag_t typedef (ITAG_W)
  - the default DP, TIMEOUT_CYC and TO_W localparams
  - the count-width function clog2(DP+1)
- One sub-module, e203_nice_itag_queue. It contains the storage, pointers, count, full and empty.
  - Interface: wen, wdat, ren, rdat, full, empty, count.
- Watchdog and handshake glue stay in the top module.

Test Plan:
- Single op, DP=4, xs_off=0, itag=2'd1 accepted: next cycle nice_o_outstanding=1 and nice_o_itag=1. Then rsp_valid with itag_ready gives nice_o_itag_valid=1 and ren. Next cycle outstanding=0 and idle=1.
- Fill: 4 accepted insns (tags 0,1,2,3) with no response → after the 4th, nice_req_valid=0 and nice_i_ready=0 while nice_i_valid=1. Four responses return the tags in order 0,1,2,3.
- Simultaneous wen and ren at count=3 → count stays 3. Pointer wrap is checked with DP=3 across 7 enqueues, with tag order preserved.
- xs_off=1 with the queue full → nice_i_ready=nice_o_ready, nice_o_longpipe=0, nice_req_valid=0, count unchanged.
- Watchdog with TIMEOUT_CYC=8: one entry outstanding, no response → nice_o_timeout rises on cycle 9 after the enqueue. A response does not clear the flag. nice_i_timeout_clr does clear it.
- Response error plus mid-run reset: rsp_err=1 gives nice_o_itag_err=1 only when itag_valid=1. Asserting rst_n=0 with 2 entries outstanding gives outstanding=0, idle=1 and timeout=0 at the next edge.
